// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types for the fetch program-counter sequencer
// Purpose: redirect priority and FSM state encodings used by pc_sequencer
//          and pc_redirect_arb.
// Contents:
//   prio_e  - redirect source priority, ordered by value so that a plain
//             magnitude compare gives the arbitration order
//   state_e - sequencer FSM states
package pc_pkg;

    typedef enum logic [1:0] {
        PRIO_NONE = 2'd0,
        PRIO_JMP  = 2'd1,
        PRIO_BR   = 2'd2,
        PRIO_EXC  = 2'd3
    } prio_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/pc_redirect_arb.sv
// rtl/pc_redirect_arb.sv - combinational redirect priority select
// Purpose: picks the highest-priority new redirect (exc > br > jmp), then
//          compares it against the buffered redirect; the new one wins ties.
// Ports:
//   exc_valid_i/exc_target_i  exception redirect request
//   br_valid_i/br_target_i    taken-branch redirect request
//   jmp_valid_i/jmp_target_i  jump redirect request
//   buf_prio_i/buf_target_i   buffered redirect (PRIO_NONE when empty)
//   win_valid_o/win_target_o/win_prio_o  overall winner
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              exc_valid_i,
    input  logic [ADDR_W-1:0] exc_target_i,
    input  logic              br_valid_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              jmp_valid_i,
    input  logic [ADDR_W-1:0] jmp_target_i,
    input  prio_e             buf_prio_i,
    input  logic [ADDR_W-1:0] buf_target_i,
    output logic              win_valid_o,
    output logic [ADDR_W-1:0] win_target_o,
    output prio_e             win_prio_o
);

    prio_e             w_new_prio;
    logic [ADDR_W-1:0] w_new_target;

    always_comb begin
        w_new_prio   = PRIO_NONE;
        w_new_target = '0;
        if (exc_valid_i) begin
            w_new_prio   = PRIO_EXC;
            w_new_target = exc_target_i;
        end else if (br_valid_i) begin
            w_new_prio   = PRIO_BR;
            w_new_target = br_target_i;
        end else if (jmp_valid_i) begin
            w_new_prio   = PRIO_JMP;
            w_new_target = jmp_target_i;
        end
    end

    // ">=" lets the newest redirect replace an equal-priority buffered one.
    always_comb begin
        win_prio_o   = buf_prio_i;
        win_target_o = buf_target_i;
        if (w_new_prio >= buf_prio_i) begin
            win_prio_o   = w_new_prio;
            win_target_o = w_new_target;
        end
        win_valid_o = (win_prio_o != PRIO_NONE);
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch program-counter sequencer with redirect buffer
// Purpose: holds the fetch PC, advances it by PC_INC per accepted request,
//          and applies exception/branch/jump redirects by priority. While
//          fetch stalls the request stays frozen and one redirect is buffered.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   fetch_ready_i                      fetch accepts pc_o this cycle
//   exc_/br_/jmp_ valid/taken, target  redirect requests
//   pc_o, pc_plus_inc_o                fetch PC and PC+step
//   pc_valid_o, redirect_o, pending_o  request valid, first-after-redirect,
//                                      redirect buffered
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                PC_INC   = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_ready_i,
    input  logic              exc_valid_i,
    input  logic [ADDR_W-1:0] exc_target_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              jmp_valid_i,
    input  logic [ADDR_W-1:0] jmp_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus_inc_o,
    output logic              pc_valid_o,
    output logic              redirect_o,
    output logic              pending_o
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_INC);

    state_e            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_redirect, w_redirect_nxt;
    prio_e             r_buf_prio, w_buf_prio_nxt;
    logic [ADDR_W-1:0] r_buf_target, w_buf_target_nxt;

    logic              w_win_valid;
    logic [ADDR_W-1:0] w_win_target;
    prio_e             w_win_prio;

    // The buffer is empty outside HOLD, so in RUN the winner is simply the
    // best new redirect; in HOLD it already applies the keep-or-overwrite rule.
    pc_redirect_arb #(
        .ADDR_W(ADDR_W)
    ) u_arb (
        .exc_valid_i  (exc_valid_i),
        .exc_target_i (exc_target_i),
        .br_valid_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .jmp_valid_i  (jmp_valid_i),
        .jmp_target_i (jmp_target_i),
        .buf_prio_i   (r_buf_prio),
        .buf_target_i (r_buf_target),
        .win_valid_o  (w_win_valid),
        .win_target_o (w_win_target),
        .win_prio_o   (w_win_prio)
    );

    assign pc_plus_inc_o = r_pc + STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_PC;
            r_valid      <= 1'b0;
            r_redirect   <= 1'b0;
            r_buf_prio   <= PRIO_NONE;
            r_buf_target <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_valid      <= w_valid_nxt;
            r_redirect   <= w_redirect_nxt;
            r_buf_prio   <= w_buf_prio_nxt;
            r_buf_target <= w_buf_target_nxt;
        end
    end

    // redirect_o describes the PC currently offered, so it is only updated
    // together with pc_o when the request is accepted.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_valid_nxt      = r_valid;
        w_redirect_nxt   = r_redirect;
        w_buf_prio_nxt   = r_buf_prio;
        w_buf_target_nxt = r_buf_target;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt    = ST_RUN;
                w_valid_nxt    = 1'b1;
                w_pc_nxt       = RESET_PC;
                w_redirect_nxt = 1'b0;
            end
            ST_RUN: begin
                if (fetch_ready_i) begin
                    w_pc_nxt       = w_win_valid ? w_win_target : pc_plus_inc_o;
                    w_redirect_nxt = w_win_valid;
                end else if (w_win_valid) begin
                    w_buf_prio_nxt   = w_win_prio;
                    w_buf_target_nxt = w_win_target;
                    w_state_nxt      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (fetch_ready_i) begin
                    w_pc_nxt         = w_win_target;
                    w_redirect_nxt   = 1'b1;
                    w_buf_prio_nxt   = PRIO_NONE;
                    w_buf_target_nxt = '0;
                    w_state_nxt      = ST_RUN;
                end else begin
                    w_buf_prio_nxt   = w_win_prio;
                    w_buf_target_nxt = w_win_target;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    assign pc_o       = r_pc;
    assign pc_valid_o = r_valid;
    assign redirect_o = r_redirect;
    assign pending_o  = (r_buf_prio != PRIO_NONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready;
    logic        exc_v, br_v, jmp_v;
    logic [31:0] exc_t, br_t, jmp_t;
    logic [31:0] pc, pc_plus;
    logic        pc_valid, redir, pend;

    logic        ready8;
    logic        exc_v8, br_v8, jmp_v8;
    logic [7:0]  exc_t8, br_t8, jmp_t8;
    logic [7:0]  pc8, pc_plus8;
    logic        pc_valid8, redir8, pend8;

    int checks = 0;
    int errors = 0;

    // Behavioural reference: the pending redirect is just a (priority, target)
    // pair; priority 0 means nothing pending.
    logic [31:0] m_pc;
    logic        m_valid, m_redir, m_boot;
    int          m_pend_prio;
    logic [31:0] m_pend_tgt;

    localparam logic [31:0] RST_PC = 32'h100;

    always #5 clk = ~clk;

    pc_sequencer #(.ADDR_W(32), .PC_INC(1), .RESET_PC(RST_PC)) u_dut (
        .clk(clk), .rst_n(rst_n), .fetch_ready_i(ready),
        .exc_valid_i(exc_v), .exc_target_i(exc_t),
        .br_taken_i(br_v), .br_target_i(br_t),
        .jmp_valid_i(jmp_v), .jmp_target_i(jmp_t),
        .pc_o(pc), .pc_plus_inc_o(pc_plus), .pc_valid_o(pc_valid),
        .redirect_o(redir), .pending_o(pend)
    );

    pc_sequencer #(.ADDR_W(8), .PC_INC(4), .RESET_PC(8'hF8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .fetch_ready_i(ready8),
        .exc_valid_i(exc_v8), .exc_target_i(exc_t8),
        .br_taken_i(br_v8), .br_target_i(br_t8),
        .jmp_valid_i(jmp_v8), .jmp_target_i(jmp_t8),
        .pc_o(pc8), .pc_plus_inc_o(pc_plus8), .pc_valid_o(pc_valid8),
        .redirect_o(redir8), .pending_o(pend8)
    );

    task automatic m_reset();
        m_pc = RST_PC; m_valid = 1'b0; m_redir = 1'b0; m_boot = 1'b1;
        m_pend_prio = 0; m_pend_tgt = '0;
    endtask

    task automatic m_update();
        int          np;
        logic [31:0] tgt;
        np  = exc_v ? 3 : br_v ? 2 : jmp_v ? 1 : 0;
        tgt = exc_v ? exc_t : br_v ? br_t : jmp_v ? jmp_t : 32'h0;
        if (m_boot) begin
            m_boot = 1'b0; m_valid = 1'b1; m_pc = RST_PC; m_redir = 1'b0;
        end else if (ready) begin
            if (m_pend_prio > np) begin
                np = m_pend_prio; tgt = m_pend_tgt;
            end
            if (np > 0) begin
                m_pc = tgt; m_redir = 1'b1;
            end else begin
                m_pc = m_pc + 32'd1; m_redir = 1'b0;
            end
            m_pend_prio = 0;
        end else if (np > 0 && np >= m_pend_prio) begin
            m_pend_prio = np; m_pend_tgt = tgt;
        end
    endtask

    task automatic clear_in();
        exc_v = 0; br_v = 0; jmp_v = 0; exc_t = 0; br_t = 0; jmp_t = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_in(); ready = 1'b1;
        rst_n = 1'b0;
        m_reset();
        #12;
        checks++; if (pc !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, RST_PC); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pc_valid); end
        checks++; if (redir !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b expected 0", redir); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", pend); end
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        clear_in(); ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_pc = RST_PC + i;
            checks++; if (pc !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, exp_pc); end
            checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, pc_valid); end
            checks++; if (redir !== 1'b0) begin errors++; $display("FAIL seq_redirect[%0d]: got %b expected 0", i, redir); end
            checks++; if (pc_plus !== exp_pc + 32'd1) begin errors++; $display("FAIL seq_plus[%0d]: got %h expected %h", i, pc_plus, exp_pc + 32'd1); end
        end
    endtask

    task automatic test_priority();
        clear_in(); ready = 1'b1;
        exc_v = 1; exc_t = 32'h80; br_v = 1; br_t = 32'h200; jmp_v = 1; jmp_t = 32'h300;
        tick();
        checks++; if (pc !== 32'h80) begin errors++; $display("FAIL prio_pc: got %h expected 00000080", pc); end
        checks++; if (redir !== 1'b1) begin errors++; $display("FAIL prio_redirect: got %b expected 1", redir); end
        clear_in();
        tick();
        checks++; if (pc !== 32'h81) begin errors++; $display("FAIL prio_after_pc: got %h expected 00000081", pc); end
        checks++; if (redir !== 1'b0) begin errors++; $display("FAIL prio_pulse: got %b expected 0", redir); end
    endtask

    task automatic test_stall();
        clear_in(); ready = 1'b1; jmp_v = 1; jmp_t = 32'h40;
        tick();
        clear_in(); ready = 1'b0; jmp_v = 1; jmp_t = 32'h300;
        tick();
        clear_in(); br_v = 1; br_t = 32'h200;
        tick();
        clear_in(); jmp_v = 1; jmp_t = 32'h300;
        tick();
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL stall_pc: got %h expected 00000040", pc); end
        checks++; if (pend !== 1'b1) begin errors++; $display("FAIL stall_pending: got %b expected 1", pend); end
        clear_in(); ready = 1'b1;
        tick();
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL stall_target: got %h expected 00000200", pc); end
        checks++; if (redir !== 1'b1) begin errors++; $display("FAIL stall_redirect: got %b expected 1", redir); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL stall_pend_clear: got %b expected 0", pend); end
    endtask

    task automatic test_tie();
        clear_in(); ready = 1'b0; jmp_v = 1; jmp_t = 32'h300;
        tick();
        clear_in(); ready = 1'b1; br_v = 1; br_t = 32'h500;
        tick();
        checks++; if (pc !== 32'h500) begin errors++; $display("FAIL tie_br: got %h expected 00000500", pc); end
        clear_in(); ready = 1'b0; jmp_v = 1; jmp_t = 32'h300;
        tick();
        clear_in(); ready = 1'b1; jmp_v = 1; jmp_t = 32'h600;
        tick();
        checks++; if (pc !== 32'h600) begin errors++; $display("FAIL tie_jmp: got %h expected 00000600", pc); end
        clear_in();
    endtask

    task automatic test_async_reset();
        clear_in(); ready = 1'b0; br_v = 1; br_t = 32'h200;
        tick();
        checks++; if (pend !== 1'b1) begin errors++; $display("FAIL arst_setup: got %b expected 1", pend); end
        #3;
        rst_n = 1'b0;
        m_reset();
        #1;
        checks++; if (pc !== RST_PC) begin errors++; $display("FAIL arst_pc: got %h expected %h", pc, RST_PC); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL arst_pending: got %b expected 0", pend); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", pc_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1; clear_in(); ready = 1'b1;
        tick();
        tick();
        checks++; if (pc !== RST_PC + 32'd1) begin errors++; $display("FAIL arst_no_stale: got %h expected %h", pc, RST_PC + 32'd1); end
        checks++; if (redir !== 1'b0) begin errors++; $display("FAIL arst_redirect: got %b expected 0", redir); end
    endtask

    task automatic test_wrap();
        clear_in(); ready = 1'b1;
        do_reset();
        tick();
        checks++; if (pc8 !== 8'hF8) begin errors++; $display("FAIL wrap_boot: got %h expected f8", pc8); end
        tick();
        checks++; if (pc8 !== 8'hFC) begin errors++; $display("FAIL wrap_fc: got %h expected fc", pc8); end
        checks++; if (pc_plus8 !== 8'h00) begin errors++; $display("FAIL wrap_plus: got %h expected 00", pc_plus8); end
        tick();
        checks++; if (pc8 !== 8'h00) begin errors++; $display("FAIL wrap_pc: got %h expected 00", pc8); end
        checks++; if (redir8 !== 1'b0) begin errors++; $display("FAIL wrap_redirect: got %b expected 0", redir8); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ready = ($urandom_range(0, 9) < 6);
            exc_v = ($urandom_range(0, 9) == 0); exc_t = $urandom();
            br_v  = ($urandom_range(0, 4) == 0); br_t  = $urandom();
            jmp_v = ($urandom_range(0, 3) == 0); jmp_t = $urandom();
            tick();
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, pc, m_pc); end
            checks++; if (pc_plus !== m_pc + 32'd1) begin errors++; $display("FAIL rnd_plus[%0d]: got %h expected %h", i, pc_plus, m_pc + 32'd1); end
            checks++; if (pc_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, pc_valid, m_valid); end
            checks++; if (redir !== m_redir) begin errors++; $display("FAIL rnd_redirect[%0d]: got %b expected %b", i, redir, m_redir); end
            checks++; if (pend !== (m_pend_prio > 0)) begin errors++; $display("FAIL rnd_pending[%0d]: got %b expected %b", i, pend, (m_pend_prio > 0)); end
        end
        clear_in();
    endtask

    initial begin
        ready8 = 1'b1; exc_v8 = 0; br_v8 = 0; jmp_v8 = 0;
        exc_t8 = 8'h0; br_t8 = 8'h0; jmp_t8 = 8'h0;
        clear_in(); ready = 1'b1; rst_n = 1'b0;
        m_reset();
        test_reset();
        test_sequential();
        test_priority();
        test_stall();
        test_tie();
        test_async_reset();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
